// File: rtl/pan_gain_coeff_engine.sv
// Per-channel gain/pan to Q2.14 left/right coefficient engine with hysteresis gating,
// saturating products and a double-buffered coefficient bank committed atomically per scan.
module pan_gain_coeff_engine #(
    parameter int    NUM_CH         = 16,
    parameter int    GAIN_W         = 10,
    parameter int    COEFF_Q        = 14,
    parameter int    GAIN_OFF_TH    = 41,
    parameter int    GAIN_ON_TH     = 61,
    parameter string GAIN_INIT_FILE = "gain_q2_14.hex",
    parameter string PAN_INIT_FILE  = "pan_lut_256_q2_14_packed.hex"
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     auto_en,
    input  logic [NUM_CH*GAIN_W-1:0] gain_bus,
    input  logic [NUM_CH*8-1:0]      pan_bus,
    input  logic [NUM_CH-1:0]        mute,
    output logic                     busy,
    output logic                     done,
    output logic [NUM_CH*16-1:0]     coeff_l,
    output logic [NUM_CH*16-1:0]     coeff_r
);

    localparam int                CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CW-1:0]     LAST_CH = CW'(NUM_CH - 1);
    localparam logic [GAIN_W-1:0] OFF_TH  = GAIN_W'(GAIN_OFF_TH);
    localparam logic [GAIN_W-1:0] ON_TH   = GAIN_W'(GAIN_ON_TH);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_ROM, S_SEL, S_MUL_L, S_MUL_R, S_WR, S_COMMIT
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]          ch;
    logic                   pend;
    logic [NUM_CH-1:0]      gate;
    logic [NUM_CH*16-1:0]   sh_l, sh_r;

    logic [15:0]            gain_rom [2**GAIN_W];
    logic [31:0]            pan_rom  [256];

    logic [GAIN_W-1:0]      gain_p0;
    logic [7:0]             pan_p0;
    logic                   mute_p0;
    logic [15:0]            gain_rd_p1;
    logic [31:0]            pan_rd_p1;
    logic [15:0]            g_eff_p2, pan_l_p2, pan_r_p2;
    logic [31:0]            prod_p3;

    function automatic logic [15:0] sat_coeff(input logic [31:0] prod);
        logic [31:0] q;
        q = prod >> COEFF_Q;
        if (q > 32'h0000_7FFF)
            return 16'h7FFF;
        return q[15:0];
    endfunction

    function automatic logic gate_pass(input logic m, input logic gate_on,
                                       input logic [GAIN_W-1:0] g);
        if (m)
            return 1'b0;
        if (gate_on)
            return (g > OFF_TH);
        return (g >= ON_TH);
    endfunction

    initial begin
        for (int i = 0; i < 2**GAIN_W; i++) gain_rom[i] = 16'h0000;
        for (int i = 0; i < 256; i++) pan_rom[i] = 32'h0000_0000;
    end

    // p0 -> p1: synchronous ROM reads; pan address is the signed pan offset by +128
    always_ff @(posedge clk) begin
        gain_rd_p1 <= gain_rom[gain_p0];
        pan_rd_p1  <= pan_rom[{~pan_p0[7], pan_p0[6:0]}];
    end

    always_ff @(posedge clk) begin
        case (state_q)
            S_REQ: begin
                gain_p0 <= gain_bus[ch*GAIN_W +: GAIN_W];
                pan_p0  <= pan_bus[ch*8 +: 8];
                mute_p0 <= mute[ch];
            end
            // p1 -> p2: split pan word, gate the gain word
            S_SEL: begin
                pan_l_p2 <= pan_rd_p1[31:16];
                pan_r_p2 <= pan_rd_p1[15:0];
                g_eff_p2 <= gate_pass(mute_p0, gate[ch], gain_p0) ? gain_rd_p1 : 16'h0000;
            end
            // p2 -> p3: shared multiplier, left then right
            S_MUL_L: prod_p3 <= 32'(g_eff_p2) * 32'(pan_l_p2);
            S_MUL_R: prod_p3 <= 32'(g_eff_p2) * 32'(pan_r_p2);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start || pend || auto_en) state_d = S_REQ;
            S_REQ:    state_d = S_ROM;
            S_ROM:    state_d = S_SEL;
            S_SEL:    state_d = S_MUL_L;
            S_MUL_L:  state_d = S_MUL_R;
            S_MUL_R:  state_d = S_WR;
            S_WR:     state_d = (ch == LAST_CH) ? S_COMMIT : S_REQ;
            S_COMMIT: state_d = (pend || auto_en) ? S_REQ : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pend    <= 1'b0;
            gate    <= '0;
            sh_l    <= '0;
            sh_r    <= '0;
            coeff_l <= '0;
            coeff_r <= '0;
        end else begin
            done <= 1'b0;
            if (start && busy)
                pend <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (start || pend || auto_en) begin
                        ch   <= '0;
                        busy <= 1'b1;
                        pend <= 1'b0;
                    end
                end
                S_REQ:   busy <= 1'b1;
                S_MUL_R: sh_l[ch*16 +: 16] <= sat_coeff(prod_p3);
                S_WR: begin
                    sh_r[ch*16 +: 16] <= sat_coeff(prod_p3);
                    gate[ch] <= gate_pass(mute_p0, gate[ch], gain_p0);
                    if (ch != LAST_CH)
                        ch <= ch + 1'b1;
                end
                // Back-to-back scans launch straight from the commit edge
                S_COMMIT: begin
                    coeff_l <= sh_l;
                    coeff_r <= sh_r;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    if (pend || auto_en) begin
                        ch   <= '0;
                        pend <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
